updown_counter_driver: RTL and testbench
========================================

UPDOWN_COUNTER_DRIVER -- requirements
Module: updown_counter_driver

Interface
REQ-001 SHALL have parameter STEP_GAP, default 0, number of idle cycles inserted between consecutive count pulses (legal 0..15).
REQ-002 SHALL have port io_in, input, 8 bits, bus that carries clock, reset and commands.
REQ-003 SHALL use io_in[0] as the clock, rising-edge active.
REQ-004 SHALL use io_in[1] as the reset, asynchronous and active-high.
REQ-005 SHALL use io_in[2] as go, the move request; its rising edge starts a move.
REQ-006 SHALL use io_in[3] as mode: 0 = step move, 1 = direct load.
REQ-007 SHALL use io_in[7:4] as target, the 4-bit requested counter value.
REQ-008 SHALL have port io_out, output, 8 bits, bus that carries counter-control signals and status.
REQ-009 SHALL drive io_out[0] as cnt_en, the count-enable pulse to the up/down counter.
REQ-010 SHALL drive io_out[1] as cnt_load, the load strobe to the counter.
REQ-011 SHALL drive io_out[2] as cnt_dir: 1 = up, 0 = down.
REQ-012 SHALL drive io_out[6:3] as data: target during a load cycle, the shadow position otherwise.
REQ-013 SHALL drive io_out[7] as busy.

Function
REQ-014 SHALL keep a 4-bit shadow position pos that mirrors the value of the attached counter.
REQ-015 SHALL register go into go_q every clock; start condition = go & ~go_q & (state == IDLE).
REQ-016 SHALL implement states IDLE, LOAD, STEP and GAP; busy = 1 in every state except IDLE.
REQ-017 IDLE, on start: SHALL capture target into tgt; SHALL go to LOAD if mode = 1, else go to STEP if target != pos, else stay in IDLE with no pulse and no busy.
REQ-018 IDLE, on entry to STEP: SHALL latch cnt_dir = 1 if (tgt - pos) mod 16 <= 8, else 0 (shortest path, tie goes up); direction stays fixed for the whole move.
REQ-019 LOAD: SHALL last exactly 1 cycle with cnt_load = 1, cnt_en = 0 and data = tgt; SHALL set pos <= tgt and return to IDLE.
REQ-020 STEP: SHALL last exactly 1 cycle with cnt_en = 1; SHALL set pos <= pos + 1 or pos - 1 mod 16 per cnt_dir (15+1 = 0, 0-1 = 15).
REQ-021 STEP exit: SHALL go to IDLE if the updated pos equals tgt; else to GAP if STEP_GAP > 0; else to STEP again.
REQ-022 GAP: SHALL hold all strobes low for exactly STEP_GAP cycles, then go to STEP.
REQ-023 Latency: SHALL make the first cnt_en or cnt_load cycle the cycle immediately after the edge that samples the start.
REQ-024 Pulse count: a step move SHALL emit exactly the path distance in cnt_en pulses (1..8 up, or 1..7 down).
REQ-025 SHALL ignore go edges, mode changes and target changes while busy; a go still held high after the move ends SHALL NOT restart a move.
REQ-026 SHALL never assert cnt_en and cnt_load in the same cycle.
REQ-027 SHALL drive cnt_en, cnt_load, cnt_dir and busy directly from registers (no combinational path from io_in to io_out).

Reset
REQ-028 Reset asserted SHALL immediately force state = IDLE, pos = 0, tgt = 0, go_q = 0, cnt_dir = 0, and therefore io_out = 8'h00.
REQ-029 Reset asserted mid-move SHALL abort the move without a further pulse; after release the block SHALL wait for a new go rising edge.

Verification
REQ-030 Pulse reset with go = 0 -> io_out = 00 during reset and after release; no strobes until the first go edge.
REQ-031 Load: mode = 1, target = 9, go rises -> one cycle with cnt_load = 1, data = 9, busy = 1; then busy = 0, data = 9.
REQ-032 Up with wrap: from pos 12, mode = 0, target = 2 -> 6 cnt_en pulses, cnt_dir = 1, pos runs 13, 14, 15, 0, 1, 2; busy drops after the 6th pulse.
REQ-033 Down move and tie: pos 2 to target 13 -> 5 pulses, cnt_dir = 0. Pos 0 to target 8 -> 8 pulses, cnt_dir = 1.
REQ-034 STEP_GAP = 3, pos 0 to target 2 -> cnt_en high in cycles 1 and 5 after the start edge, busy for 5 cycles. Target equal to pos -> no pulse and busy stays 0.
REQ-035 Second go edge during a move -> ignored. Reset asserted after the 2nd of 5 pulses -> io_out = 00 at once, pos = 0, no further pulses.

Source files
------------

// File: rtl/updown_counter_driver.sv
// updown_counter_driver
//   Drives an external 4-bit up/down counter toward a requested value. It does
//   this either with a single load strobe or with a train of count-enable
//   pulses that take the shortest path around the 16-value ring. A 4-bit
//   shadow position tracks the counter's value.
//
// Parameters
//   STEP_GAP  idle cycles inserted between consecutive count pulses (0..15)
//
// Ports
//   io_in[0]    clock, rising edge
//   io_in[1]    reset, asynchronous, active high
//   io_in[2]    go; a rising edge starts a move
//   io_in[3]    mode: 0 = step move, 1 = direct load
//   io_in[7:4]  target value
//   io_out[0]   cnt_en    count-enable pulse
//   io_out[1]   cnt_load  load strobe
//   io_out[2]   cnt_dir   1 = up, 0 = down
//   io_out[6:3] data      target during a load cycle, shadow position otherwise
//   io_out[7]   busy
module updown_counter_driver #(
  parameter int unsigned STEP_GAP = 0
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_GAP
  } state_t;

  logic       w_clk;
  logic       w_rst;
  logic       w_go;
  logic       w_mode;
  logic [3:0] w_target;

  assign w_clk    = io_in[0];
  assign w_rst    = io_in[1];
  assign w_go     = io_in[2];
  assign w_mode   = io_in[3];
  assign w_target = io_in[7:4];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_pos;
  logic [3:0] r_tgt;
  logic       r_go_q;
  logic       r_dir;
  logic [3:0] r_gap;

  logic       w_start;
  logic [3:0] w_dist;
  logic [3:0] w_pos_step;

  assign w_start    = w_go & ~r_go_q & (r_state == S_IDLE);
  // Forward distance on the ring; 0..8 is reached faster (or equally fast) going up.
  assign w_dist     = w_target - r_pos;
  assign w_pos_step = r_dir ? (r_pos + 4'd1) : (r_pos - 4'd1);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_mode)
            w_state_nxt = S_LOAD;
          else if (w_target != r_pos)
            w_state_nxt = S_STEP;
        end
      end
      S_LOAD: w_state_nxt = S_IDLE;
      S_STEP: begin
        if (w_pos_step == r_tgt)
          w_state_nxt = S_IDLE;
        else if (STEP_GAP > 0)
          w_state_nxt = S_GAP;
        else
          w_state_nxt = S_STEP;
      end
      S_GAP: begin
        if (r_gap == '0)
          w_state_nxt = S_STEP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_tgt   <= '0;
      r_go_q  <= 1'b0;
      r_dir   <= 1'b0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_go_q  <= w_go;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_tgt <= w_target;
            // Direction is frozen here for the whole move.
            if (!w_mode && (w_target != r_pos))
              r_dir <= (w_dist <= 4'd8);
          end
        end
        S_LOAD: r_pos <= r_tgt;
        S_STEP: begin
          r_pos <= w_pos_step;
          // Gap counter runs STEP_GAP-1 down to 0, giving exactly STEP_GAP idle cycles.
          r_gap <= 4'(STEP_GAP - 1);
        end
        S_GAP: r_gap <= r_gap - 4'd1;
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, so nothing on io_in reaches io_out combinationally.
  logic w_busy;
  logic w_en;
  logic w_load;

  assign w_busy = (r_state != S_IDLE);
  assign w_en   = (r_state == S_STEP);
  assign w_load = (r_state == S_LOAD);

  assign io_out = {w_busy, (w_load ? r_tgt : r_pos), r_dir, w_load, w_en};

endmodule

// File: tb/tb_updown_counter_driver.sv
module tb_updown_counter_driver;

  typedef struct {
    int         cyc;
    logic [7:0] out;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] target = '0;
  logic [7:0] io_in;
  logic [7:0] o0;
  logic [7:0] o3;

  int   cyc = 0;
  int   total = 0;
  int   pass = 0;
  logic exp_dir = 1'b0;
  exp_t q0[$];
  exp_t q3[$];

  assign io_in = {target, mode, go, rst, clk};

  updown_counter_driver #(.STEP_GAP(0)) dut0 (.io_in(io_in), .io_out(o0));
  updown_counter_driver #(.STEP_GAP(3)) dut3 (.io_in(io_in), .io_out(o3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mk(input logic busy, input logic [3:0] data,
                                    input logic dir, input logic load, input logic en);
    return {busy, data, dir, load, en};
  endfunction

  // Scoreboard monitors: every strobe cycle must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (o0[0] | o0[1]) begin
      total++;
      if (q0.size() == 0)
        $display("FAIL dut0_strobe: got cyc=%0d out=%h, expected no strobe", cyc, o0);
      else begin
        e = q0.pop_front();
        if (e.cyc == cyc && e.out == o0) pass++;
        else $display("FAIL dut0_strobe: got cyc=%0d out=%h, expected cyc=%0d out=%h",
                      cyc, o0, e.cyc, e.out);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (o3[0] | o3[1]) begin
      total++;
      if (q3.size() == 0)
        $display("FAIL dut3_strobe: got cyc=%0d out=%h, expected no strobe", cyc, o3);
      else begin
        e = q3.pop_front();
        if (e.cyc == cyc && e.out == o3) pass++;
        else $display("FAIL dut3_strobe: got cyc=%0d out=%h, expected cyc=%0d out=%h",
                      cyc, o3, e.cyc, e.out);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act == expv) pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
  endtask

  task automatic start(input logic m, input logic [3:0] t, output int s);
    @(negedge clk);
    #1;
    mode   = m;
    target = t;
    go     = 1'b1;
    s      = cyc + 1;
  endtask

  task automatic push_steps(input int n, input logic d, input logic [3:0] p0, input int s);
    logic [3:0] p;
    p = p0;
    for (int k = 0; k < n; k++) begin
      q0.push_back('{s + k,     mk(1'b1, p, d, 1'b0, 1'b1)});
      q3.push_back('{s + 4 * k, mk(1'b1, p, d, 1'b0, 1'b1)});
      p = d ? p + 4'd1 : p - 4'd1;
    end
  endtask

  task automatic wait_idle(input bit toggle, output int b0, output int b3);
    bit done;
    done = 1'b0;
    b0 = 0;
    b3 = 0;
    for (int it = 0; it < 80 && !done; it++) begin
      @(negedge clk);
      if (o0[7]) b0++;
      if (o3[7]) b3++;
      if (!o0[7] && !o3[7]) done = 1'b1;
      if (toggle && it == 0) begin
        #1; go = 1'b0; mode = 1'b1; target = 4'd0;
      end
      if (toggle && it == 1) begin
        #1; go = 1'b1;
      end
    end
    if (!done) begin
      total++;
      $display("FAIL idle_timeout: got busy=%b/%b, expected 0/0", o0[7], o3[7]);
    end
  endtask

  task automatic do_move(input logic m, input logic [3:0] t, input int n,
                         input logic d, input logic [3:0] p0);
    int s, b0, b3;
    start(m, t, s);
    if (m) begin
      q0.push_back('{s, mk(1'b1, t, exp_dir, 1'b1, 1'b0)});
      q3.push_back('{s, mk(1'b1, t, exp_dir, 1'b1, 1'b0)});
    end else begin
      push_steps(n, d, p0, s);
      if (n > 0) exp_dir = d;
    end
    wait_idle(1'b0, b0, b3);
    chk("busy_cycles_gap0", b0, m ? 1 : n);
    chk("busy_cycles_gap3", b3, m ? 1 : (n > 0 ? 4 * n - 3 : 0));
    chk("idle_out_gap0", int'(o0), int'(mk(1'b0, t, exp_dir, 1'b0, 1'b0)));
    chk("idle_out_gap3", int'(o3), int'(mk(1'b0, t, exp_dir, 1'b0, 1'b0)));
    #1;
    go = 1'b0;
  endtask

  initial begin
    int s, b0, b3;

    // Reset held with go low, then released: everything zero.
    repeat (3) @(negedge clk);
    chk("reset_out_gap0", int'(o0), 0);
    chk("reset_out_gap3", int'(o3), 0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_gap0", int'(o0), 0);
    chk("post_reset_gap3", int'(o3), 0);

    do_move(1'b1, 4'd9,  0, 1'b0, 4'd0);   // direct load 9
    do_move(1'b1, 4'd12, 0, 1'b0, 4'd9);   // load 12
    do_move(1'b0, 4'd2,  6, 1'b1, 4'd12);  // 12 -> 2 up through wrap
    do_move(1'b0, 4'd13, 5, 1'b0, 4'd2);   // 2 -> 13 down through wrap
    do_move(1'b1, 4'd0,  0, 1'b0, 4'd13);  // load 0
    do_move(1'b0, 4'd8,  8, 1'b1, 4'd0);   // tie distance 8 goes up
    do_move(1'b1, 4'd0,  0, 1'b0, 4'd8);   // load 0
    do_move(1'b0, 4'd2,  2, 1'b1, 4'd0);   // 0 -> 2 (gap spacing)
    do_move(1'b0, 4'd2,  0, 1'b1, 4'd2);   // target equals pos: no move

    // Second go edge and input changes during a move are ignored;
    // go left high afterwards does not restart.
    start(1'b0, 4'd7, s);
    push_steps(5, 1'b1, 4'd2, s);
    exp_dir = 1'b1;
    wait_idle(1'b1, b0, b3);
    chk("busy_ignore_gap0", b0, 5);
    chk("busy_ignore_gap3", b3, 17);
    chk("ignore_out_gap0", int'(o0), int'(mk(1'b0, 4'd7, 1'b1, 1'b0, 1'b0)));
    repeat (4) @(negedge clk);
    chk("held_go_gap0", int'(o0), int'(mk(1'b0, 4'd7, 1'b1, 1'b0, 1'b0)));
    chk("held_go_gap3", int'(o3), int'(mk(1'b0, 4'd7, 1'b1, 1'b0, 1'b0)));
    #1 go = 1'b0;

    // Reset mid-move after the 2nd pulse of the gap-0 instance.
    start(1'b0, 4'd12, s);
    q0.push_back('{s,     mk(1'b1, 4'd7, 1'b1, 1'b0, 1'b1)});
    q0.push_back('{s + 1, mk(1'b1, 4'd8, 1'b1, 1'b0, 1'b1)});
    q3.push_back('{s,     mk(1'b1, 4'd7, 1'b1, 1'b0, 1'b1)});
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    go  = 1'b0;
    #1;
    chk("async_reset_gap0", int'(o0), 0);
    chk("async_reset_gap3", int'(o3), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("after_abort_gap0", int'(o0), 0);
    chk("after_abort_gap3", int'(o3), 0);
    chk("pending_gap0", q0.size(), 0);
    chk("pending_gap3", q3.size(), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
